// File: rtl/demux_1to_16_deser_pkg.sv
// Shared constants and state type for the 1-to-16 demultiplexer / deserializer.
//   N_CH  : number of channels and assembled word width (only 16 is supported)
//   SEL_W : channel index width, log2(N_CH)
//   state_e : COLLECT (accepting serial bits) / FULL (word parked, waiting on Y)
package demux_1to_16_deser_pkg;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

endpackage

// File: rtl/demux_1to_16_dec.sv
// Channel write-enable decoder: turns a channel index into a one-hot write
// enable, the structural inverse of the 16:1 mux select path.
//   idx : channel index
//   en  : enable; when low no channel is written
//   we  : one-hot write enable, we[idx] = en
module demux_1to_16_dec
    import demux_1to_16_deser_pkg::*;
(
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [N_CH-1:0]  we
);

    always_comb begin
        we = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            we[i] = en && (idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/demux_1to_16_deser.sv
// Registered 1-to-16 demultiplexer and deserializer. Serial bits are steered to
// channel chan_idx of a collection register; the completed 16-bit word moves to
// a one-word output register with a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   din        : serial data bit, accepted when din_valid && din_ready
//   din_valid  : din is valid
//   din_ready  : registered, high whenever the state is COLLECT
//   sof        : start of frame, accepted bit becomes channel 0
//   Y          : assembled word, first accepted bit in Y[0]
//   y_valid    : Y holds an unconsumed word
//   y_ready    : consumer takes Y when y_valid && y_ready
//   chan_idx   : channel the next accepted bit is written to
//   frame_err  : one-cycle pulse when sof arrives mid-word
module demux_1to_16_deser
    import demux_1to_16_deser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sof,
    output logic [N_CH-1:0]  Y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [SEL_W-1:0] chan_idx,
    output logic             frame_err
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  chan_idx_q, chan_idx_d;
    logic [N_CH-1:0]   coll_q, coll_d;
    logic [N_CH-1:0]   y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              din_ready_q, din_ready_d;

    logic              accept;
    logic              drain;
    logic [SEL_W-1:0]  wr_idx;
    logic [N_CH-1:0]   we;
    logic [N_CH-1:0]   coll_base;
    logic [N_CH-1:0]   coll_wr;

    assign accept = din_valid && din_ready_q;
    assign drain  = y_valid_q && y_ready;
    // sof forces the bit into channel 0 regardless of where the counter is
    assign wr_idx = sof ? '0 : chan_idx_q;

    demux_1to_16_dec u_dec (
        .idx (wr_idx),
        .en  (accept),
        .we  (we)
    );

    // sof drops the partial word, so the new frame starts from a clean register
    assign coll_base = sof ? '0 : coll_q;
    assign coll_wr   = (coll_base & ~we) | (we & {N_CH{din}});

    always_comb begin
        state_d     = state_q;
        chan_idx_d  = chan_idx_q;
        coll_d      = coll_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        frame_err_d = 1'b0;

        if (drain) begin
            y_valid_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (sof) begin
                        frame_err_d = (chan_idx_q != '0);
                        chan_idx_d  = SEL_W'(1);
                        coll_d      = coll_wr;
                    end else if (chan_idx_q == SEL_W'(N_CH - 1)) begin
                        chan_idx_d = '0;
                        if (!y_valid_q || y_ready) begin
                            y_d       = coll_wr;
                            y_valid_d = 1'b1;
                            coll_d    = '0;
                        end else begin
                            // output register occupied: park the word and stall input
                            coll_d  = coll_wr;
                            state_d = FULL;
                        end
                    end else begin
                        chan_idx_d = chan_idx_q + SEL_W'(1);
                        coll_d     = coll_wr;
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    y_d        = coll_q;
                    y_valid_d  = 1'b1;
                    coll_d     = '0;
                    chan_idx_d = '0;
                    state_d    = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // registered from next state, so y_ready never reaches din_ready combinationally
        din_ready_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            chan_idx_q  <= '0;
            coll_q      <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            chan_idx_q  <= chan_idx_d;
            coll_q      <= coll_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign din_ready = din_ready_q;
    assign Y         = y_q;
    assign y_valid   = y_valid_q;
    assign chan_idx  = chan_idx_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_demux_1to_16_deser.sv
module tb_demux_1to_16_deser;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        din_ready;
    logic        sof;
    logic [15:0] Y;
    logic        y_valid;
    logic        y_ready;
    logic [3:0]  chan_idx;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    demux_1to_16_deser dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sof       (sof),
        .Y         (Y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .chan_idx  (chan_idx),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: completed words not yet consumed, bits of the word in progress,
    // last word handed to the consumer, and a pending frame error.
    logic [15:0] outq[$];
    bit          pbits[$];
    logic [15:0] last_y = 16'h0000;
    logic        ferr_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shown_y();
        return (outq.size() > 0) ? outq[0] : last_y;
    endfunction

    // Monitor: on each falling edge compare DUT state with the model, then apply
    // the transfers that the next rising edge will perform.
    initial begin
        logic        acc;
        logic [15:0] w;
        forever begin
            @(negedge clk);
            chk("y_valid",   {31'b0, y_valid},   {31'b0, outq.size() > 0});
            chk("Y",         {16'b0, Y},         {16'b0, shown_y()});
            chk("din_ready", {31'b0, din_ready}, {31'b0, outq.size() < 2});
            chk("chan_idx",  {28'b0, chan_idx},  pbits.size());
            chk("frame_err", {31'b0, frame_err}, {31'b0, ferr_exp});
            if (rst) begin
                outq.delete();
                pbits.delete();
                last_y   = 16'h0000;
                ferr_exp = 1'b0;
            end else begin
                ferr_exp = 1'b0;
                acc = din_valid && (outq.size() < 2);
                if (y_ready && outq.size() > 0) begin
                    chk("handshake_word", {16'b0, Y}, {16'b0, outq[0]});
                    last_y = outq.pop_front();
                end
                if (acc) begin
                    if (sof) begin
                        if (pbits.size() != 0) ferr_exp = 1'b1;
                        pbits.delete();
                    end
                    pbits.push_back(din);
                    if (pbits.size() == 16) begin
                        w = '0;
                        for (int i = 0; i < 16; i++) w[i] = pbits[i];
                        outq.push_back(w);
                        pbits.delete();
                    end
                end
            end
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        sof       = 1'b0;
        repeat (n) tick();
    endtask

    // Present one bit and hold it until accepted (bounded wait).
    task automatic send_bit(input logic b, input logic s);
        int n;
        din       = b;
        sof       = s;
        din_valid = 1'b1;
        if (rand_ready) y_ready = 1'($urandom_range(0, 1));
        n = 0;
        while (!din_ready && n < 200) begin
            tick();
            if (rand_ready) y_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: din_ready got 0 expected 1 at %0t", $time);
        end
        tick();
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic first_sof, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            send_bit(w[i], (i == 0) ? first_sof : 1'b0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        y_ready   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        // single word, then back-to-back words
        send_word(16'hA5C3, 1'b0, 0);
        idle(3);
        send_word(16'h1234, 1'b0, 0);
        send_word(16'hFFFF, 1'b0, 0);
        idle(3);

        // backpressure: hold one word in Y, park the next, then release
        y_ready = 1'b0;
        send_word(16'h00FF, 1'b0, 0);
        send_word(16'h8001, 1'b0, 0);
        idle(4);
        y_ready = 1'b1;
        idle(4);

        // sof mid-word drops the 5-bit fragment
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        send_word(16'h7E7E, 1'b1, 0);
        idle(3);

        // gaps between bits
        send_word(16'hC0DE, 1'b0, 3);
        idle(3);

        // reset mid-word, then a clean word
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        send_word(16'hBEEF, 1'b0, 0);
        idle(3);

        // random words, random consumer stalls, occasional sof
        rand_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            logic [15:0] rw;
            rw = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                send_bit(rw[i], ($urandom_range(0, 23) == 0) || (i == 0 && k[0]));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_ready = 1'b0;
        y_ready    = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
